// File: rtl/iaaa_reg_pkg.sv
// Shared register-code definitions for the IAAA datapath.
// The register write-enable decoder and the read-side bus selector both use
// these constants, so the two sides always agree on the code map.
package iaaa_reg_pkg;

  // Width of a register code on both the read and write side
  localparam int CODE_W = 5;

  // Number of bus-readable registers (R1..R14, PC, TOTR, MDDR, TR, AR)
  localparam int NUM_REGS = 19;

  // Register codes
  localparam logic [CODE_W-1:0] REG_NONE = 5'd0;
  localparam logic [CODE_W-1:0] REG_R1   = 5'd1;
  localparam logic [CODE_W-1:0] REG_R2   = 5'd2;
  localparam logic [CODE_W-1:0] REG_R3   = 5'd3;
  localparam logic [CODE_W-1:0] REG_R4   = 5'd4;
  localparam logic [CODE_W-1:0] REG_R5   = 5'd5;
  localparam logic [CODE_W-1:0] REG_R6   = 5'd6;
  localparam logic [CODE_W-1:0] REG_R7   = 5'd7;
  localparam logic [CODE_W-1:0] REG_R8   = 5'd8;
  localparam logic [CODE_W-1:0] REG_R9   = 5'd9;
  localparam logic [CODE_W-1:0] REG_R10  = 5'd10;
  localparam logic [CODE_W-1:0] REG_R11  = 5'd11;
  localparam logic [CODE_W-1:0] REG_R12  = 5'd12;
  localparam logic [CODE_W-1:0] REG_R13  = 5'd13;
  localparam logic [CODE_W-1:0] REG_R14  = 5'd14;
  localparam logic [CODE_W-1:0] REG_PC   = 5'd15;
  localparam logic [CODE_W-1:0] REG_TOTR = 5'd16;
  localparam logic [CODE_W-1:0] REG_MDDR = 5'd17;
  localparam logic [CODE_W-1:0] REG_TR   = 5'd18;
  localparam logic [CODE_W-1:0] REG_AR   = 5'd19;
  // Write-side broadcast; never a legal read source
  localparam logic [CODE_W-1:0] REG_ALL  = 5'd31;

  // Read selector sequencing
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    DONE = 2'd2
  } rbus_state_t;

  // Map a legal code (1..19) to its slice position counted from the LS end
  // of the packed register vector: R1 is the MS slice (18), AR the LS (0).
  function automatic logic [CODE_W-1:0] code_to_slice(input logic [CODE_W-1:0] code);
    return 5'(NUM_REGS) - code;
  endfunction

endpackage

// File: rtl/rbus_code_check.sv
// Combinational legality check for a register read code.
// legal : code selects one of R1..AR (1..19)
// zero  : code 0, a no-op read that drives the bus to zero
// idx   : slice position of the selected register (0 when not legal)
module rbus_code_check (
  input  logic [4:0] code,
  output logic       legal,
  output logic       zero,
  output logic [4:0] idx
);
  import iaaa_reg_pkg::*;

  // Classify the code and compute the slice index for legal codes
  always_comb begin
    legal = (code >= REG_R1) && (code <= REG_AR);
    zero  = (code == REG_NONE);
    idx   = legal ? code_to_slice(code) : '0;
  end

endmodule

// File: rtl/rbus_read_sel.sv
// Register-file read-side bus source selector.
// A request latches a 5-bit register code; one cycle later the selected
// register slice is loaded onto the registered bus output, and the cycle
// after that the result is flagged with Rd_valid (and Rd_err for illegal
// codes). Optional feature macro: RBUS_PARITY_EN adds the Bus_par output.
module rbus_read_sel #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 19
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  input  logic                       Rd_req,
  input  logic [4:0]                 Rd_code,
  input  logic [NUM_REGS*DATA_W-1:0] Reg_in,
  output logic [DATA_W-1:0]          Bus_out,
  output logic                       Rd_valid,
  output logic                       Rd_err,
  output logic                       Rd_busy
`ifdef RBUS_PARITY_EN
  ,
  output logic                       Bus_par
`endif
);
  import iaaa_reg_pkg::*;

  rbus_state_t       state;
  logic [4:0]        code_q;
  logic              err_q;

  logic              code_legal;
  logic              code_zero;
  logic [4:0]        code_idx;
  logic [DATA_W-1:0] sel_data;

`ifdef RBUS_PARITY_EN
  // Even parity of a bus word: XOR of all bits
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  // Classify the latched code; only consulted while in SEL
  rbus_code_check u_code_check (
    .code  (code_q),
    .legal (code_legal),
    .zero  (code_zero),
    .idx   (code_idx)
  );

  // Select the register slice addressed by the latched code
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (code_idx == 5'(i)) begin
        sel_data = Reg_in[i*DATA_W +: DATA_W];
      end
    end
  end

  // Read sequencer: IDLE accepts, SEL loads the bus, DONE reports
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      code_q   <= '0;
      err_q    <= 1'b0;
      Bus_out  <= '0;
      Rd_valid <= 1'b0;
      Rd_err   <= 1'b0;
      Rd_busy  <= 1'b0;
`ifdef RBUS_PARITY_EN
      Bus_par  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          Rd_valid <= 1'b0;
          Rd_err   <= 1'b0;
          if (Rd_req) begin
            code_q  <= Rd_code;
            state   <= SEL;
            Rd_busy <= 1'b1;
          end else begin
            Rd_busy <= 1'b0;
          end
        end

        SEL: begin
          // Reg_in is sampled only here; illegal codes leave the bus alone
          if (code_legal) begin
            Bus_out <= sel_data;
`ifdef RBUS_PARITY_EN
            Bus_par <= even_par(sel_data);
`endif
          end else if (code_zero) begin
            Bus_out <= '0;
`ifdef RBUS_PARITY_EN
            Bus_par <= 1'b0;
`endif
          end else begin
            err_q <= 1'b1;
          end
          // Outputs for DONE are registered here so they track err_q exactly
          Rd_valid <= 1'b1;
          Rd_err   <= !code_legal && !code_zero;
          Rd_busy  <= 1'b1;
          state    <= DONE;
        end

        DONE: begin
          err_q    <= 1'b0;
          Rd_valid <= 1'b0;
          Rd_err   <= 1'b0;
          Rd_busy  <= 1'b0;
          state    <= IDLE;
        end

        default: begin
          err_q    <= 1'b0;
          Rd_valid <= 1'b0;
          Rd_err   <= 1'b0;
          Rd_busy  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rbus_read_sel.sv
// Directed testbench for rbus_read_sel: table-driven single reads plus
// hand-written sequences for back-to-back requests, input sampling and
// reset in mid-operation. Parity checks are built when RBUS_PARITY_EN is set.
module tb_rbus_read_sel;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 19;

  logic                       Clock;
  logic                       Reset_n;
  logic                       Rd_req;
  logic [4:0]                 Rd_code;
  logic [NUM_REGS*DATA_W-1:0] Reg_in;
  logic [DATA_W-1:0]          Bus_out;
  logic                       Rd_valid;
  logic                       Rd_err;
  logic                       Rd_busy;
`ifdef RBUS_PARITY_EN
  logic                       Bus_par;
`endif

  int checks;
  int errors;

  rbus_read_sel #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) dut (
    .Clock    (Clock),
    .Reset_n  (Reset_n),
    .Rd_req   (Rd_req),
    .Rd_code  (Rd_code),
    .Reg_in   (Reg_in),
    .Bus_out  (Bus_out),
    .Rd_valid (Rd_valid),
    .Rd_err   (Rd_err),
    .Rd_busy  (Rd_busy)
`ifdef RBUS_PARITY_EN
    ,
    .Bus_par  (Bus_par)
`endif
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  code;
    logic [15:0] exp_bus;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Code k lives at Reg_in[(20-k)*DATA_W-1 -: DATA_W]
  task automatic set_reg(input int k, input logic [15:0] val);
    Reg_in[(20-k)*DATA_W-1 -: DATA_W] = val;
  endtask

  // One full read: accept edge, SEL edge, DONE edge, checking each phase
  task automatic do_read(input string name, input logic [4:0] code,
                         input logic [15:0] exp_bus, input logic exp_err);
    @(negedge Clock);
    Rd_req  = 1'b1;
    Rd_code = code;
    @(posedge Clock);
    #1;
    Rd_req = 1'b0;
    check({name, " busy after accept"}, 32'(Rd_busy), 32'd1);
    check({name, " no valid in SEL"}, 32'(Rd_valid), 32'd0);
    @(posedge Clock);
    #1;
    check({name, " valid"}, 32'(Rd_valid), 32'd1);
    check({name, " err"}, 32'(Rd_err), 32'(exp_err));
    check({name, " bus"}, 32'(Bus_out), 32'(exp_bus));
    @(posedge Clock);
    #1;
    check({name, " valid drops"}, 32'(Rd_valid), 32'd0);
    check({name, " idle not busy"}, 32'(Rd_busy), 32'd0);
    check({name, " bus holds"}, 32'(Bus_out), 32'(exp_bus));
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    Reset_n = 1'b0;
    Rd_req  = 1'b0;
    Rd_code = '0;
    Reg_in  = '0;
    for (int k = 1; k <= NUM_REGS; k++) set_reg(k, 16'h1000 + 16'(k));

    vecs[0] = '{code: 5'd1,  exp_bus: 16'h1001, exp_err: 1'b0};
    vecs[1] = '{code: 5'd5,  exp_bus: 16'h1005, exp_err: 1'b0};
    vecs[2] = '{code: 5'd31, exp_bus: 16'h1005, exp_err: 1'b1};
    vecs[3] = '{code: 5'd0,  exp_bus: 16'h0000, exp_err: 1'b0};
    vecs[4] = '{code: 5'd20, exp_bus: 16'h0000, exp_err: 1'b1};
    vecs[5] = '{code: 5'd19, exp_bus: 16'h1013, exp_err: 1'b0};
    vecs[6] = '{code: 5'd25, exp_bus: 16'h1013, exp_err: 1'b1};
    vecs[7] = '{code: 5'd14, exp_bus: 16'h100E, exp_err: 1'b0};

    // Reset state
    repeat (2) @(posedge Clock);
    #1;
    check("reset bus", 32'(Bus_out), 32'd0);
    check("reset valid", 32'(Rd_valid), 32'd0);
    check("reset err", 32'(Rd_err), 32'd0);
    check("reset busy", 32'(Rd_busy), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;

    // Table-driven single reads
    for (int i = 0; i < 8; i++) begin
      do_read($sformatf("vec%0d", i), vecs[i].code, vecs[i].exp_bus, vecs[i].exp_err);
    end

    // Back to back with Rd_req held: code 19 then 15; the code change while
    // busy must not affect the in-flight read
    @(negedge Clock);
    Rd_req  = 1'b1;
    Rd_code = 5'd19;
    @(posedge Clock);
    #1;
    Rd_code = 5'd15;
    check("b2b first busy", 32'(Rd_busy), 32'd1);
    @(posedge Clock);
    #1;
    check("b2b first bus", 32'(Bus_out), 32'h1013);
    check("b2b first valid", 32'(Rd_valid), 32'd1);
    @(posedge Clock);
    #1;
    check("b2b idle gap", 32'(Rd_busy), 32'd0);
    check("b2b valid once", 32'(Rd_valid), 32'd0);
    @(posedge Clock);
    #1;
    Rd_req = 1'b0;
    check("b2b second accepted", 32'(Rd_busy), 32'd1);
    check("b2b bus before SEL", 32'(Bus_out), 32'h1013);
    @(posedge Clock);
    #1;
    check("b2b second bus", 32'(Bus_out), 32'h100F);
    check("b2b second valid", 32'(Rd_valid), 32'd1);
    check("b2b second err", 32'(Rd_err), 32'd0);
    @(posedge Clock);
    #1;

    // Reg_in changes outside SEL have no effect on the bus
    set_reg(15, 16'hBEEF);
    repeat (3) @(posedge Clock);
    #1;
    check("reg_in ignored idle", 32'(Bus_out), 32'h100F);
    check("no spurious valid", 32'(Rd_valid), 32'd0);
    set_reg(15, 16'h100F);

    // Reset asserted during SEL discards the read
    @(negedge Clock);
    Rd_req  = 1'b1;
    Rd_code = 5'd3;
    @(posedge Clock);
    #1;
    Rd_req = 1'b0;
    #1;
    Reset_n = 1'b0;
    #1;
    check("midrst bus", 32'(Bus_out), 32'd0);
    check("midrst busy", 32'(Rd_busy), 32'd0);
    check("midrst valid", 32'(Rd_valid), 32'd0);
    @(negedge Clock);
    Reset_n = 1'b1;
    repeat (3) begin
      @(posedge Clock);
      #1;
      check("midrst no valid later", 32'(Rd_valid), 32'd0);
      check("midrst bus stays", 32'(Bus_out), 32'd0);
    end
    do_read("after reset", 5'd2, 16'h1002, 1'b0);

`ifdef RBUS_PARITY_EN
    set_reg(6, 16'h0007);
    set_reg(7, 16'h0003);
    do_read("par7", 5'd6, 16'h0007, 1'b0);
    check("par of 0007", 32'(Bus_par), 32'd1);
    do_read("par3", 5'd7, 16'h0003, 1'b0);
    check("par of 0003", 32'(Bus_par), 32'd0);
    do_read("par7 again", 5'd6, 16'h0007, 1'b0);
    do_read("par illegal", 5'd31, 16'h0007, 1'b1);
    check("par holds illegal", 32'(Bus_par), 32'd1);
    do_read("par zero", 5'd0, 16'h0000, 1'b0);
    check("par of zero", 32'(Bus_par), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
